// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester arbiter in front of the single-port data memory.
//   Requester 0 is the pipeline MEM stage (cpu_*), requester 1 is the
//   load/debug DMA port (dma_*). One access is granted at a time. It is issued
//   to the memory in an IDLE cycle and acknowledged with a registered ack and
//   read data in the following ACK cycle. Misaligned or out-of-range
//   addresses never reach the memory. They still complete, with err set.
//
//   Optional feature macro: DMEM_ARB_RR_EN
//     defined   : ties are resolved by strict round robin (the requester that
//                 did not win the last grant wins); MAX_WAIT is ignored.
//     undefined : cpu has priority, but a dma that has waited MAX_WAIT
//                 contended IDLE cycles wins the next grant.
//
//   Ports
//     clk, reset                       clock (rising edge), async active-high reset
//     cpu_req/we/addr/wdata   (in)     cpu request; req held until cpu_ack
//     cpu_ack, cpu_rdata      (out)    one-cycle completion pulse, read data
//     cpu_stall               (out)    cpu_req & ~cpu_ack, to hazard unit
//     dma_req/we/addr/wdata   (in)     dma request, same rules as cpu
//     dma_ack, dma_rdata      (out)    dma completion pulse, read data
//     err                     (out)    pulses with ack for an illegal access
//     mem_read/write/addr/wdata (out)  data memory control
//     mem_rdata               (in)     data memory combinational read data
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int RAM_SIZE_BIT = 8,
  parameter int MAX_WAIT     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_ACK  = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dma_ack_q, dma_ack_d;
  logic        err_q, err_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;

`ifdef DMEM_ARB_RR_EN
  // 1 = dma won the most recent grant.
  logic        last_dma_q, last_dma_d;
`else
  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  logic [3:0]  wait_cnt_q, wait_cnt_d;
`endif

  logic        any_req;
  logic        dma_wins;
  logic        issue;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        addr_legal;
  logic [31:0] capture;

  // Grant selection; only meaningful while issue is high.
  always_comb begin
    any_req = cpu_req | dma_req;
    if (dma_req && !cpu_req) begin
      dma_wins = 1'b1;
    end else if (dma_req && cpu_req) begin
`ifdef DMEM_ARB_RR_EN
      dma_wins = ~last_dma_q;
`else
      dma_wins = (wait_cnt_q == MAX_WAIT_C);
`endif
    end else begin
      dma_wins = 1'b0;
    end
  end

  assign issue     = (state_q == S_IDLE) && any_req;
  assign sel_we    = dma_wins ? dma_we    : cpu_we;
  assign sel_addr  = dma_wins ? dma_addr  : cpu_addr;
  assign sel_wdata = dma_wins ? dma_wdata : cpu_wdata;

  // Word aligned and inside the 2^RAM_SIZE_BIT-word memory.
  assign addr_legal = (sel_addr[1:0] == 2'b00) &&
                      (sel_addr[31:RAM_SIZE_BIT+2] == '0);

  // Memory port is idle (all zeros) in ACK and when nobody asks.
  assign mem_read  = issue & addr_legal & ~sel_we;
  assign mem_write = issue & addr_legal &  sel_we;
  assign mem_addr  = issue ? sel_addr  : '0;
  assign mem_wdata = issue ? sel_wdata : '0;

  // Legal reads return memory data, illegal accesses return zero, and legal
  // writes leave the winner's read data register untouched.
  always_comb begin
    if (!addr_legal)  capture = '0;
    else if (!sel_we) capture = mem_rdata;
    else              capture = dma_wins ? dma_rdata_q : cpu_rdata_q;
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no branch can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    err_d       = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
`ifdef DMEM_ARB_RR_EN
    last_dma_d  = last_dma_q;
`else
    wait_cnt_d  = wait_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ACK;
          err_d   = ~addr_legal;
          if (dma_wins) begin
            dma_ack_d   = 1'b1;
            dma_rdata_d = capture;
          end else begin
            cpu_ack_d   = 1'b1;
            cpu_rdata_d = capture;
          end
`ifdef DMEM_ARB_RR_EN
          last_dma_d = dma_wins;
`else
          // Starvation guard: count contended IDLE cycles lost by dma.
          if (dma_wins)                                 wait_cnt_d = '0;
          else if (dma_req && wait_cnt_q != MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 4'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_dma_q  <= 1'b1;
`else
      wait_cnt_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // that existed before this edge, independent of statement order.
      state_q     <= state_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
`ifdef DMEM_ARB_RR_EN
      last_dma_q  <= last_dma_d;
`else
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign err       = err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. A transaction-level reference model
//   (reference memory, pending completion, per-requester read data, dma
//   wait count) predicts every output. It is compared on every falling
//   edge. Hand-computed literal checks pin the model in the directed tests.
//   Build with +define+DMEM_ARB_RR_EN to check the round-robin variant.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int RSB   = 8;
  localparam int MAXW  = 4;
  localparam int WORDS = 1 << RSB;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic        cpu_ack, dma_ack, cpu_stall, err;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.RAM_SIZE_BIT(RSB), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata), .err(err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory instance seen by the DUT: combinational read, write on edge.
  logic [31:0] ram [0:WORDS-1];
  assign mem_rdata = ram[mem_addr[RSB+1:2]];
  always @(posedge clk) if (mem_write) ram[mem_addr[RSB+1:2]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:WORDS-1];
  bit          m_pending;       // a completion is being acknowledged this cycle
  bit          m_owner_dma;
  bit          m_err;
  logic [31:0] m_rd [2];
  int          m_wait;
  bit          m_last_dma;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 4 * WORDS);
  endfunction

  function automatic bit pick_dma();
    if (dma_req && !cpu_req) return 1'b1;
    if (cpu_req && !dma_req) return 1'b0;
`ifdef DMEM_ARB_RR_EN
    return !m_last_dma;
`else
    return m_wait >= MAXW;
`endif
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pending = 0; m_err = 0; m_rd[0] = '0; m_rd[1] = '0;
      m_wait = 0; m_last_dma = 1; m_owner_dma = 0;
    end else if (m_pending) begin
      m_pending = 0;
    end else if (cpu_req || dma_req) begin
      bit w; logic [31:0] a; logic [31:0] d; bit we;
      w  = pick_dma();
      a  = w ? dma_addr  : cpu_addr;
      d  = w ? dma_wdata : cpu_wdata;
      we = w ? dma_we    : cpu_we;
      if (!legal(a))  m_rd[w] = '0;
      else if (we)    ref_mem[a / 4] = d;
      else            m_rd[w] = ref_mem[a / 4];
      if (w)            m_wait = 0;
      else if (dma_req) m_wait = (m_wait + 1 > MAXW) ? MAXW : m_wait + 1;
      m_err = !legal(a); m_owner_dma = w; m_last_dma = w; m_pending = 1;
    end
  end

  // One compare process, every falling edge.
  always @(negedge clk) begin
    bit e_cack, e_dack, e_rd, e_wr, w;
    logic [31:0] e_addr, e_wd, a;
    e_cack = m_pending && !m_owner_dma;
    e_dack = m_pending &&  m_owner_dma;
    check("cpu_ack", cpu_ack, e_cack);
    check("dma_ack", dma_ack, e_dack);
    check("err", err, m_pending && m_err);
    check("cpu_rdata", cpu_rdata, m_rd[0]);
    check("dma_rdata", dma_rdata, m_rd[1]);
    if (!reset) begin
      check("cpu_stall", cpu_stall, cpu_req && !e_cack);
      e_rd = 0; e_wr = 0; e_addr = '0; e_wd = '0;
      if (!m_pending && (cpu_req || dma_req)) begin
        w = pick_dma();
        a = w ? dma_addr : cpu_addr;
        e_addr = a;
        e_wd   = w ? dma_wdata : cpu_wdata;
        e_rd   = legal(a) && !(w ? dma_we : cpu_we);
        e_wr   = legal(a) &&  (w ? dma_we : cpu_we);
      end
      check("mem_read", mem_read, e_rd);
      check("mem_write", mem_write, e_wr);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wd);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic access(input bit who_dma, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output bit saw_rd, output bit saw_wr, output bit got_err);
    bit done = 0;
    rdata = '0; got_err = 0;
    @(posedge clk); #1;
    if (who_dma) begin dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wdata; end
    else         begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
    #1;
    saw_rd = mem_read; saw_wr = mem_write;
    for (int i = 0; i < 8 && !done; i++) begin
      @(posedge clk); #1;
      if (who_dma ? dma_ack : cpu_ack) begin
        rdata   = who_dma ? dma_rdata : cpu_rdata;
        got_err = err;
        done    = 1;
        if (who_dma) dma_req = 0; else cpu_req = 0;
      end
    end
    if (!done) begin
      check("ack_timeout", 32'd0, 32'd1);
      cpu_req = 0; dma_req = 0;
    end
  endtask

  // Both requesters hold req; n grants are observed and checked in order.
  task automatic contend(input int n, input string tag);
    int got = 0;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
    dma_req = 1; dma_we = 0; dma_addr = 32'h3FC;
    for (int i = 0; i < 2 * n; i++) begin
      bit exp_dma;
      @(posedge clk); #1;
      if (cpu_ack || dma_ack) begin
`ifdef DMEM_ARB_RR_EN
        exp_dma = (got % 2) == 1;
`else
        exp_dma = (got % (MAXW + 1)) == MAXW;
`endif
        check($sformatf("%s_grant%0d_dma", tag, got), {31'd0, dma_ack}, {31'd0, exp_dma});
        check($sformatf("%s_grant%0d_cpu", tag, got), {31'd0, cpu_ack}, {31'd0, !exp_dma});
        got++;
      end
    end
    check({tag, "_grant_count"}, got, n);
    cpu_req = 0; dma_req = 0;
  endtask

  // ---------------- directed tests ----------------
  logic [31:0] rd;
  bit s_rd, s_wr, s_err;

  initial begin
    for (int i = 0; i < WORDS; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_dma_ack", dma_ack, 0);
    check("rst_err", err, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_mem_rw", {mem_read, mem_write}, 0);
    #3 reset = 0;

    // cpu write then read back
    access(0, 1, 32'h10, 32'hDEADBEEF, rd, s_rd, s_wr, s_err);
    check("t1_wr_mem_write", s_wr, 1);
    check("t1_wr_err", s_err, 0);
    access(0, 0, 32'h10, '0, rd, s_rd, s_wr, s_err);
    check("t1_rd_mem_read", s_rd, 1);
    check("t1_rd_data", rd, 32'hDEADBEEF);

    // dma at the last word and just past it
    access(1, 1, 32'h3FC, 32'h0BADF00D, rd, s_rd, s_wr, s_err);
    access(1, 0, 32'h3FC, '0, rd, s_rd, s_wr, s_err);
    check("t3_last_mem_read", s_rd, 1);
    check("t3_last_data", rd, 32'h0BADF00D);
    check("t3_last_err", s_err, 0);
    access(1, 0, 32'h400, '0, rd, s_rd, s_wr, s_err);
    check("t3_oob_mem_read", s_rd, 0);
    check("t3_oob_data", rd, 0);
    check("t3_oob_err", s_err, 1);
    access(1, 0, 32'h8000_0000, '0, rd, s_rd, s_wr, s_err);
    check("t3_hi_err", s_err, 1);

    // contention right after a dma grant: dma wait count is zero
    contend(10, "c1");

    // misaligned cpu write must not touch word 0x4
    access(0, 1, 32'h4, 32'hCAFEF00D, rd, s_rd, s_wr, s_err);
    access(0, 1, 32'h6, 32'h12345678, rd, s_rd, s_wr, s_err);
    check("t4_mis_mem_write", s_wr, 0);
    check("t4_mis_err", s_err, 1);
    access(0, 0, 32'h4, '0, rd, s_rd, s_wr, s_err);
    check("t4_readback", rd, 32'hCAFEF00D);

    // async reset during the ACK cycle of a dma read
    @(posedge clk); #1;
    dma_req = 1; dma_we = 0; dma_addr = 32'h3FC;
    @(posedge clk); #1;
    check("t5_ack_before_rst", dma_ack, 1);
    #1 reset = 1;
    #1;
    check("t5_ack_async_clear", dma_ack, 0);
    check("t5_rdata_async_clear", dma_rdata, 0);
    dma_req = 0;
    repeat (2) @(posedge clk);
    #2 reset = 0;
    access(1, 0, 32'h3FC, '0, rd, s_rd, s_wr, s_err);
    check("t5_reissue_data", rd, 32'h0BADF00D);
    contend(5, "c2");

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
